// File: rtl/dma_desc_scheduler.sv
// ---------------------------------------------------------------------------
// dma_desc_scheduler
//   Collects DMA descriptors from N_REQ requesters through a round-robin
//   arbiter into a descriptor FIFO, then launches them one at a time on
//   dma_func_wrapper. It tracks done / error / timeout for each transfer and
//   returns a one-cycle completion tagged with the requester ID.
//
// Ports
//   clk, rstn                clock, async active-low reset
//   enable_i                 allow launching of queued descriptors
//   flush_i                  drop every queued (not in-flight) descriptor
//   clr_halt_i               leave HALT after an error or a timeout
//   req_valid_i/req_ready_o  per-requester handshake (ready is a one-hot grant)
//   req_desc_i               flattened descriptors, requester i at slice i
//   dma_go_o, dma_desc_o     launch pulse and descriptor to the DMA engine
//   dma_stats_i, dma_error_i status and error from the DMA engine
//   cpl_valid_o/id/err/tmo   completion pulse and its attributes
//   busy_o, halted_o         FSM in GO/BUSY, FSM in HALT
//   q_count_o                FIFO occupancy
// ---------------------------------------------------------------------------
package dma_desc_sched_pkg;
    typedef struct packed {
        logic [31:0] src_addr;
        logic [31:0] dst_addr;
        logic [31:0] num_bytes;
    } s_dma_desc_t;

    typedef struct packed {
        logic busy;
        logic done;
    } s_dma_status_t;

    typedef struct packed {
        logic rd_err;
        logic wr_err;
    } s_dma_error_t;
endpackage

module dma_desc_scheduler
    import dma_desc_sched_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int QDEPTH      = 8,
    parameter int TIMEOUT_CYC = 65536,
    parameter int ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               enable_i,
    input  logic                               flush_i,
    input  logic                               clr_halt_i,
    input  logic [N_REQ-1:0]                   req_valid_i,
    input  logic [N_REQ*$bits(s_dma_desc_t)-1:0] req_desc_i,
    output logic [N_REQ-1:0]                   req_ready_o,
    output logic                               dma_go_o,
    output logic [$bits(s_dma_desc_t)-1:0]     dma_desc_o,
    input  s_dma_status_t                      dma_stats_i,
    input  s_dma_error_t                       dma_error_i,
    output logic                               cpl_valid_o,
    output logic [ID_W-1:0]                    cpl_id_o,
    output logic                               cpl_err_o,
    output logic                               cpl_tmo_o,
    output logic                               busy_o,
    output logic                               halted_o,
    output logic [$clog2(QDEPTH+1)-1:0]        q_count_o
);

    localparam int DW = $bits(s_dma_desc_t);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH+1);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;

    typedef struct packed {
        logic [ID_W-1:0] id;
        s_dma_desc_t     desc;
    } s_entry_t;

    typedef enum logic [1:0] {S_IDLE, S_GO, S_BUSY, S_HALT} e_state_t;

    // ------------------------------------------------------------------
    // Arbiter
    // ------------------------------------------------------------------
    s_dma_desc_t      w_req_desc [N_REQ];
    logic [N_REQ-1:0] w_grant;
    logic [ID_W-1:0]  w_win;
    logic [ID_W-1:0]  w_idx;
    logic             w_push;
    logic             w_full;
    logic [ID_W-1:0]  r_rr;
    logic [CW-1:0]    r_count;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_req_desc[g] = req_desc_i[g*DW +: DW];
    end

    assign w_full = (r_count == CW'(QDEPTH));

    // Scan from the RR pointer upward, wrapping; the first valid wins.
    always_comb begin
        w_grant = '0;
        w_win   = '0;
        w_idx   = '0;
        if (!w_full && !flush_i) begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                w_idx = ID_W'((int'(r_rr) + k) % N_REQ);
                if (req_valid_i[w_idx]) begin
                    w_grant = '0;
                    w_grant[w_idx] = 1'b1;
                    w_win = w_idx;
                end
            end
        end
    end

    assign w_push      = |w_grant;
    assign req_ready_o = w_grant;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr <= '0;
        end else if (w_push) begin
            if (int'(w_win) == N_REQ - 1) r_rr <= '0;
            else                          r_rr <= w_win + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Descriptor FIFO
    // ------------------------------------------------------------------
    s_entry_t      r_mem [QDEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    s_entry_t      w_head;
    logic          w_pop;

    assign w_head = r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= {w_win, w_req_desc[w_win]};
    end

    // Flush snaps the read pointer onto the write pointer; the arbiter is
    // blocked during flush, so no push can race it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_rd    <= r_wr;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign q_count_o = r_count;

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    e_state_t      r_state;
    e_state_t      w_next;
    s_entry_t      r_cur;
    logic          r_done_q;
    logic [TW-1:0] r_timer;
    logic          w_head_zero;
    logic          w_err;
    logic          w_done_rise;
    logic          w_tmo;
    logic          w_unused;

    assign w_unused    = dma_stats_i.busy;
    assign w_pop       = (r_state == S_IDLE) && enable_i && (r_count != '0) && !flush_i;
    assign w_head_zero = (w_head.desc.num_bytes == '0);
    assign w_err       = |dma_error_i;
    assign w_done_rise = dma_stats_i.done & ~r_done_q;
    assign w_tmo       = (TIMEOUT_CYC != 0) && (r_timer == TMO_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_cur    <= '0;
            r_done_q <= 1'b0;
            r_timer  <= '0;
        end else begin
            r_state  <= w_next;
            r_done_q <= dma_stats_i.done;
            if (w_pop) r_cur <= w_head;
            // Timer only runs in BUSY; leaving GO always starts it from zero.
            if (r_state == S_BUSY) r_timer <= r_timer + 1'b1;
            else                   r_timer <= '0;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_pop && !w_head_zero) w_next = S_GO;
            S_GO:   w_next = S_BUSY;
            // Error outranks done; done outranks a coincident timeout.
            S_BUSY: begin
                if (w_err)            w_next = S_HALT;
                else if (w_done_rise) w_next = S_IDLE;
                else if (w_tmo)       w_next = S_HALT;
            end
            S_HALT: if (clr_halt_i) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        dma_go_o   = (r_state == S_GO);
        dma_desc_o = (r_state == S_GO) ? r_cur.desc : '0;
        busy_o     = (r_state == S_GO) || (r_state == S_BUSY);
        halted_o   = (r_state == S_HALT);
    end

    // ------------------------------------------------------------------
    // Completion (registered one cycle after the terminating event)
    // ------------------------------------------------------------------
    logic            w_cpl_v, w_cpl_err, w_cpl_tmo;
    logic [ID_W-1:0] w_cpl_id;

    always_comb begin
        w_cpl_v   = 1'b0;
        w_cpl_id  = '0;
        w_cpl_err = 1'b0;
        w_cpl_tmo = 1'b0;
        case (r_state)
            // Zero-length descriptors complete at pop without touching the DMA.
            S_IDLE: if (w_pop && w_head_zero) begin
                w_cpl_v  = 1'b1;
                w_cpl_id = w_head.id;
            end
            S_BUSY: begin
                if (w_err) begin
                    w_cpl_v   = 1'b1;
                    w_cpl_id  = r_cur.id;
                    w_cpl_err = 1'b1;
                end else if (w_done_rise) begin
                    w_cpl_v  = 1'b1;
                    w_cpl_id = r_cur.id;
                end else if (w_tmo) begin
                    w_cpl_v   = 1'b1;
                    w_cpl_id  = r_cur.id;
                    w_cpl_tmo = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cpl_valid_o <= 1'b0;
            cpl_id_o    <= '0;
            cpl_err_o   <= 1'b0;
            cpl_tmo_o   <= 1'b0;
        end else begin
            cpl_valid_o <= w_cpl_v;
            cpl_id_o    <= w_cpl_id;
            cpl_err_o   <= w_cpl_err;
            cpl_tmo_o   <= w_cpl_tmo;
        end
    end

endmodule

// File: tb/tb_dma_desc_scheduler.sv
module tb_dma_desc_scheduler;
    import dma_desc_sched_pkg::*;

    localparam int N  = 4;
    localparam int Q  = 8;
    localparam int T  = 16;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic enable = 1'b0, flush = 1'b0, clr = 1'b0;
    logic [N-1:0] valid = '0;
    s_dma_desc_t descs [N];
    logic [N*96-1:0] req_desc;
    logic [N-1:0] ready;
    logic dma_go;
    logic [95:0] dma_desc;
    s_dma_status_t stats;
    s_dma_error_t err_in = '0;
    logic cpl_valid, cpl_err, cpl_tmo, busy, halted;
    logic [IW-1:0] cpl_id;
    logic [3:0] q_count;

    logic auto_en = 1'b0, auto_done = 1'b0, man_done = 1'b0;
    int   cd = 0;
    int   n_cmp = 0, n_fail = 0;

    s_dma_desc_t go_q [$];
    logic [3:0]  cpl_q [$];   // {id, err, tmo}

    assign req_desc = {descs[3], descs[2], descs[1], descs[0]};
    assign stats    = {1'b0, auto_done | man_done};

    always #5 clk = ~clk;

    dma_desc_scheduler #(.N_REQ(N), .QDEPTH(Q), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rstn(rstn), .enable_i(enable), .flush_i(flush), .clr_halt_i(clr),
        .req_valid_i(valid), .req_desc_i(req_desc), .req_ready_o(ready),
        .dma_go_o(dma_go), .dma_desc_o(dma_desc), .dma_stats_i(stats), .dma_error_i(err_in),
        .cpl_valid_o(cpl_valid), .cpl_id_o(cpl_id), .cpl_err_o(cpl_err), .cpl_tmo_o(cpl_tmo),
        .busy_o(busy), .halted_o(halted), .q_count_o(q_count)
    );

    // DMA stand-in: raises done for one cycle, three cycles after seeing go.
    always @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            cd = 0;
            auto_done = 1'b0;
        end else begin
            if (auto_done) auto_done = 1'b0;
            if (cd > 0) begin
                cd = cd - 1;
                if (cd == 0) auto_done = 1'b1;
            end else if (dma_go && auto_en) begin
                cd = 3;
            end
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (dma_go)    go_q.push_back(s_dma_desc_t'(dma_desc));
            if (cpl_valid) cpl_q.push_back({cpl_id, cpl_err, cpl_tmo});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; enable = 1'b0; flush = 1'b0; clr = 1'b0; valid = '0;
        man_done = 1'b0; err_in = '0; auto_en = 1'b0;
        repeat (2) step();
        rstn = 1'b1;
        go_q.delete();
        cpl_q.delete();
    endtask

    task automatic load_std_descs();
        for (int i = 0; i < N; i++)
            descs[i] = '{src_addr: 32'(i), dst_addr: 32'h2000_0000 + 32'(i * 256),
                         num_bytes: 32'(16 * (i + 1))};
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) step();
        n_cmp++; if (dma_go !== 1'b0)      begin n_fail++; $display("FAIL rst_go: got %b want 0", dma_go); end
        n_cmp++; if (dma_desc !== '0)      begin n_fail++; $display("FAIL rst_desc: got %h want 0", dma_desc); end
        n_cmp++; if (cpl_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_cpl: got %b want 0", cpl_valid); end
        n_cmp++; if (cpl_id !== '0)        begin n_fail++; $display("FAIL rst_cpl_id: got %0d want 0", cpl_id); end
        n_cmp++; if (busy !== 1'b0 || halted !== 1'b0)
                     begin n_fail++; $display("FAIL rst_state: busy %b halted %b want 0 0", busy, halted); end
        n_cmp++; if (q_count !== 4'd0)     begin n_fail++; $display("FAIL rst_count: got %0d want 0", q_count); end
        n_cmp++; if (ready !== 4'b0000)    begin n_fail++; $display("FAIL rst_ready: got %b want 0000", ready); end
        rstn = 1'b1;
    endtask

    task automatic test_single();
        s_dma_desc_t d0;
        d0 = '{src_addr: 32'h0, dst_addr: 32'h1100_0000, num_bytes: 32'h30};
        do_reset();
        descs[0] = d0; enable = 1'b1; auto_en = 1'b1; valid = 4'b0001;
        #1;
        n_cmp++; if (ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b want 0001", ready); end
        step(); valid = '0;
        n_cmp++; if (q_count !== 4'd1 || dma_go !== 1'b0)
                     begin n_fail++; $display("FAIL single_queued: count %0d go %b want 1 0", q_count, dma_go); end
        step();
        n_cmp++; if (dma_go !== 1'b1 || dma_desc !== d0)
                     begin n_fail++; $display("FAIL single_go: go %b desc %h want 1 %h", dma_go, dma_desc, d0); end
        step();
        n_cmp++; if (dma_go !== 1'b0 || busy !== 1'b1 || dma_desc !== '0)
                     begin n_fail++; $display("FAIL single_busy: go %b busy %b desc %h want 0 1 0", dma_go, busy, dma_desc); end
        for (int c = 0; c < 20 && cpl_q.size() < 1; c++) step();
        n_cmp++; if (cpl_q.size() != 1 || cpl_q[0] !== 4'b0000)
                     begin n_fail++; $display("FAIL single_cpl: n %0d first %b want 1 0000", cpl_q.size(), cpl_q.size() ? cpl_q[0] : 4'hx); end
        n_cmp++; if (go_q.size() != 1) begin n_fail++; $display("FAIL single_go_count: got %0d want 1", go_q.size()); end
    endtask

    task automatic test_fill_rr();
        do_reset();
        load_std_descs();
        valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_cmp++; if (ready !== 4'(1 << (i % 4)))
                         begin n_fail++; $display("FAIL fill_grant%0d: got %b want %b", i, ready, 4'(1 << (i % 4))); end
            step();
        end
        #1;
        n_cmp++; if (ready !== 4'b0000 || q_count !== 4'd8)
                     begin n_fail++; $display("FAIL fill_full: ready %b count %0d want 0000 8", ready, q_count); end
        valid = '0; enable = 1'b1; auto_en = 1'b1;
        for (int c = 0; c < 200 && cpl_q.size() < 8; c++) step();
        n_cmp++; if (cpl_q.size() != 8) begin n_fail++; $display("FAIL fill_cpl_count: got %0d want 8", cpl_q.size()); end
        for (int j = 0; j < cpl_q.size() && j < 8; j++) begin
            n_cmp++; if (cpl_q[j] !== {2'(j % 4), 2'b00})
                         begin n_fail++; $display("FAIL fill_cpl%0d: got %b want %b", j, cpl_q[j], {2'(j % 4), 2'b00}); end
        end
        for (int j = 0; j < go_q.size() && j < 8; j++) begin
            n_cmp++; if (go_q[j].src_addr !== 32'(j % 4) || go_q[j].num_bytes !== 32'(16 * (j % 4 + 1)))
                         begin n_fail++; $display("FAIL fill_go%0d: src %h len %h want %h %h", j, go_q[j].src_addr,
                                                  go_q[j].num_bytes, 32'(j % 4), 32'(16 * (j % 4 + 1))); end
        end
    endtask

    task automatic test_zero_len();
        do_reset();
        descs[1] = '{src_addr: 32'h100, dst_addr: 32'h200, num_bytes: 32'h0};
        enable = 1'b1; auto_en = 1'b1; valid = 4'b0010;
        #1;
        n_cmp++; if (ready !== 4'b0010) begin n_fail++; $display("FAIL zero_ready: got %b want 0010", ready); end
        step(); valid = '0;
        n_cmp++; if (cpl_valid !== 1'b0 || q_count !== 4'd1)
                     begin n_fail++; $display("FAIL zero_pre: cpl %b count %0d want 0 1", cpl_valid, q_count); end
        step();
        n_cmp++; if ({cpl_valid, cpl_id, cpl_err, cpl_tmo} !== 5'b1_01_00)
                     begin n_fail++; $display("FAIL zero_cpl: got %b want 10100", {cpl_valid, cpl_id, cpl_err, cpl_tmo}); end
        n_cmp++; if (busy !== 1'b0 || dma_go !== 1'b0)
                     begin n_fail++; $display("FAIL zero_nolaunch: busy %b go %b want 0 0", busy, dma_go); end
        step();
        n_cmp++; if (cpl_valid !== 1'b0 || cpl_id !== '0)
                     begin n_fail++; $display("FAIL zero_pulse: valid %b id %0d want 0 0", cpl_valid, cpl_id); end
        repeat (5) step();
        n_cmp++; if (go_q.size() != 0) begin n_fail++; $display("FAIL zero_go_count: got %0d want 0", go_q.size()); end
    endtask

    task automatic test_error_halt();
        do_reset();
        load_std_descs();
        enable = 1'b1; valid = 4'b1111;
        repeat (4) step();
        valid = '0;
        n_cmp++; if (q_count !== 4'd3 || busy !== 1'b1)
                     begin n_fail++; $display("FAIL err_setup: count %0d busy %b want 3 1", q_count, busy); end
        err_in = 2'b01; man_done = 1'b1;
        step();
        n_cmp++; if ({cpl_valid, cpl_id, cpl_err, cpl_tmo} !== 5'b1_00_10 || halted !== 1'b1)
                     begin n_fail++; $display("FAIL err_cpl: got %b halted %b want 10010 1",
                                              {cpl_valid, cpl_id, cpl_err, cpl_tmo}, halted); end
        err_in = '0; man_done = 1'b0;
        repeat (5) step();
        n_cmp++; if (go_q.size() != 1 || q_count !== 4'd3 || halted !== 1'b1)
                     begin n_fail++; $display("FAIL err_hold: gos %0d count %0d halted %b want 1 3 1",
                                              go_q.size(), q_count, halted); end
        auto_en = 1'b1; clr = 1'b1;
        step(); clr = 1'b0;
        n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL err_clr: halted %b want 0", halted); end
        for (int c = 0; c < 100 && cpl_q.size() < 4; c++) step();
        n_cmp++; if (cpl_q.size() != 4 || go_q.size() != 4)
                     begin n_fail++; $display("FAIL err_resume_count: cpl %0d go %0d want 4 4", cpl_q.size(), go_q.size()); end
        for (int j = 1; j < cpl_q.size() && j < 4; j++) begin
            n_cmp++; if (cpl_q[j] !== {2'(j), 2'b00})
                         begin n_fail++; $display("FAIL err_resume%0d: got %b want %b", j, cpl_q[j], {2'(j), 2'b00}); end
        end
    endtask

    // GO occupies one cycle, then BUSY runs 16 cycles (timer 0..15); the
    // timeout is seen in the 16th BUSY cycle and the completion is
    // registered on the following edge, i.e. 17 samples after the GO sample.
    task automatic test_timeout();
        int n;
        do_reset();
        descs[2] = '{src_addr: 32'h300, dst_addr: 32'h400, num_bytes: 32'h40};
        enable = 1'b1; valid = 4'b0100;
        step(); valid = '0;
        step();
        n_cmp++; if (dma_go !== 1'b1) begin n_fail++; $display("FAIL tmo_go: got %b want 1", dma_go); end
        n = 0;
        while (n < 40 && cpl_valid !== 1'b1) begin
            step();
            n++;
        end
        n_cmp++; if (n != 17) begin n_fail++; $display("FAIL tmo_latency: got %0d want 17", n); end
        n_cmp++; if ({cpl_valid, cpl_id, cpl_err, cpl_tmo} !== 5'b1_10_01 || halted !== 1'b1)
                     begin n_fail++; $display("FAIL tmo_cpl: got %b halted %b want 11001 1",
                                              {cpl_valid, cpl_id, cpl_err, cpl_tmo}, halted); end
        clr = 1'b1;
        step(); clr = 1'b0;
        n_cmp++; if (halted !== 1'b0 || busy !== 1'b0)
                     begin n_fail++; $display("FAIL tmo_clr: halted %b busy %b want 0 0", halted, busy); end
    endtask

    task automatic test_flush();
        do_reset();
        load_std_descs();
        enable = 1'b1; valid = 4'b1111;
        repeat (6) step();
        valid = '0;
        n_cmp++; if (q_count !== 4'd5 || busy !== 1'b1)
                     begin n_fail++; $display("FAIL flush_setup: count %0d busy %b want 5 1", q_count, busy); end
        flush = 1'b1; valid = 4'b0100;
        #1;
        n_cmp++; if (ready !== 4'b0000) begin n_fail++; $display("FAIL flush_block: ready %b want 0000", ready); end
        step(); flush = 1'b0; valid = '0;
        n_cmp++; if (q_count !== 4'd0 || busy !== 1'b1 || cpl_valid !== 1'b0)
                     begin n_fail++; $display("FAIL flush_empty: count %0d busy %b cpl %b want 0 1 0",
                                              q_count, busy, cpl_valid); end
        man_done = 1'b1;
        step(); man_done = 1'b0;
        n_cmp++; if ({cpl_valid, cpl_id, cpl_err, cpl_tmo} !== 5'b1_00_00)
                     begin n_fail++; $display("FAIL flush_cpl: got %b want 10000", {cpl_valid, cpl_id, cpl_err, cpl_tmo}); end
        auto_en = 1'b1;
        repeat (20) step();
        n_cmp++; if (go_q.size() != 1 || cpl_q.size() != 1)
                     begin n_fail++; $display("FAIL flush_after: go %0d cpl %0d want 1 1", go_q.size(), cpl_q.size()); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        load_std_descs();
        enable = 1'b1; valid = 4'b0111;
        repeat (3) step();
        valid = '0;
        n_cmp++; if (busy !== 1'b1 || q_count !== 4'd2)
                     begin n_fail++; $display("FAIL mid_setup: busy %b count %0d want 1 2", busy, q_count); end
        rstn = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || q_count !== 4'd0 || halted !== 1'b0)
                     begin n_fail++; $display("FAIL mid_reset: busy %b count %0d halted %b want 0 0 0",
                                              busy, q_count, halted); end
        step(); rstn = 1'b1;
        repeat (3) step();
        n_cmp++; if (dma_go !== 1'b0 || q_count !== 4'd0)
                     begin n_fail++; $display("FAIL mid_after: go %b count %0d want 0 0", dma_go, q_count); end
    endtask

    initial begin
        for (int i = 0; i < N; i++) descs[i] = '0;
        test_reset();
        test_single();
        test_fill_rr();
        test_zero_len();
        test_error_halt();
        test_timeout();
        test_flush();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
